// File: rtl/rv32i_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mem_pkg
// Brief    : Shared types and default widths for the RV32I memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_mem_pkg;

    localparam int c_def_addr_w  = 32;
    localparam int c_def_data_w  = 32;
    localparam int c_def_mem_lat = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Combinational fetch/data picker. Fixed data-over-fetch priority,
//            or round-robin on ties when ARB_RR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import rv32i_mem_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_t last_grant,
    output logic   gnt_valid,
    output owner_t winner
);

    assign gnt_valid = if_req | d_req;

`ifdef ARB_RR_EN
    always_comb begin
        winner = OWN_D;
        if (if_req && d_req) begin
            // On a tie the port that did not win last time goes first
            winner = (last_grant == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = (last_grant == OWN_D);
    assign winner        = d_req ? OWN_D : OWN_IF;
`endif

endmodule
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mem_arbiter
// Brief    : Shares one fixed-latency single-port memory between the fetch
//            and load/store ports, one transaction outstanding at a time.
// Config   : ARB_RR_EN selects round-robin tie breaking (see mem_arb_pick).
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W  = c_def_addr_w,
    parameter int DATA_W  = c_def_data_w,
    parameter int MEM_LAT = c_def_mem_lat
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int                 c_cnt_w    = $clog2(MEM_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MEM_LAT);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    arb_state_t         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    owner_t             r_owner, w_owner_nxt;
    owner_t             r_last, w_last_nxt;
    logic               r_store, w_store_nxt;
    logic [DATA_W-1:0]  r_if_rdata, r_d_rdata;
    logic               w_capture;
    logic               w_pick_valid;
    owner_t             w_winner;

    // r_last only feeds the picker; with fixed priority it is pruned away
    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (r_last),
        .gnt_valid  (w_pick_valid),
        .winner     (w_winner)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_store_nxt = r_store;
        w_capture   = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;

        if (reset) begin
            if (r_state == RESP) begin
                if_rvalid = (r_owner == OWN_IF);
                d_rvalid  = (r_owner == OWN_D);
            end

            if (r_state != WAIT) begin
                w_state_nxt = IDLE;
                if (w_pick_valid) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = c_cnt_load;
                    w_owner_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    mem_en      = 1'b1;
                    if (w_winner == OWN_D) begin
                        d_gnt       = 1'b1;
                        mem_we      = d_we;
                        mem_be      = d_be;
                        mem_addr    = d_addr;
                        mem_wdata   = d_wdata;
                        w_store_nxt = d_we;
                    end else begin
                        if_gnt      = 1'b1;
                        mem_be      = '1;
                        mem_addr    = if_addr;
                        w_store_nxt = 1'b0;
                    end
                end
            end else if (r_cnt == c_cnt_one) begin
                // mem_rdata is valid in this cycle, exactly MEM_LAT after the grant
                w_capture   = 1'b1;
                w_state_nxt = RESP;
            end else begin
                w_cnt_nxt = r_cnt - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_owner    <= OWN_IF;
            r_last     <= OWN_IF;
            r_store    <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_store <= w_store_nxt;
            if (w_capture) begin
                if (r_owner == OWN_D) begin
                    r_d_rdata <= r_store ? '0 : mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_mem_arbiter
// Brief    : Randomized self-checking bench for rv32i_mem_arbiter against a
//            transaction-level reference model and a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_arbiter;

    localparam int MEM_LAT     = 2;
    localparam int RAND_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Behavioural memory: unwritten words return an address hash
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_sched [int];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F);
    endfunction

    // Stimulus state
    logic        rst_v, rand_mode, if_hold;
    logic        p_if_req, p_d_req, p_d_we;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
    logic [3:0]  p_d_be;

    // Reference model: one transaction, response due MEM_LAT+1 after its grant
    logic        m_busy, m_own_d, m_last_d, m_rd_known;
    int          m_g;
    logic [31:0] m_data, m_if_rd, m_d_rd;

    function automatic logic [31:0] rand_addr();
        return 32'h100 + 32'($urandom_range(0, 15)) * 4;
    endfunction

    task automatic new_d_req(input int pct);
        p_d_req   = ($urandom_range(0, 99) < pct);
        p_d_we    = $urandom_range(0, 1) == 1;
        p_d_be    = 4'($urandom_range(0, 15));
        p_d_addr  = rand_addr();
        p_d_wdata = $urandom;
    endtask

    task automatic cycle();
        logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, grant, win_d;
        logic [5:0]  e_ctl;
        logic [31:0] e_addr, e_wdata, old;
        @(negedge clk);
        reset     = rst_v;
        if_req    = p_if_req;
        if_addr   = p_if_addr;
        d_req     = p_d_req;
        d_we      = p_d_we;
        d_be      = p_d_be;
        d_addr    = p_d_addr;
        d_wdata   = p_d_wdata;
        mem_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : $urandom;
        #1;
        e_if_rv = 1'b0;
        e_d_rv  = 1'b0;
        if (m_busy && cyc == m_g + MEM_LAT + 1) begin
            if (m_own_d) m_d_rd = m_data;
            else         m_if_rd = m_data;
            e_if_rv = rst_v && !m_own_d;
            e_d_rv  = rst_v && m_own_d;
            m_busy  = 1'b0;
        end
        grant = rst_v && !m_busy && (p_if_req || p_d_req);
        win_d = p_d_req;
`ifdef ARB_RR_EN
        if (p_if_req && p_d_req) win_d = !m_last_d;
`endif
        e_if_gnt = grant && !win_d;
        e_d_gnt  = grant && win_d;
        e_ctl    = '0;
        e_addr   = '0;
        e_wdata  = '0;
        if (e_d_gnt) begin
            e_ctl   = {1'b1, p_d_we, p_d_be};
            e_addr  = p_d_addr;
            e_wdata = p_d_wdata;
        end else if (e_if_gnt) begin
            e_ctl  = 6'b10_1111;
            e_addr = p_if_addr;
        end

        check_eq("if_gnt", {31'd0, if_gnt}, {31'd0, e_if_gnt});
        check_eq("d_gnt", {31'd0, d_gnt}, {31'd0, e_d_gnt});
        check_eq("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_if_rv});
        check_eq("d_rvalid", {31'd0, d_rvalid}, {31'd0, e_d_rv});
        check_eq("mem_ctl", {26'd0, mem_en, mem_we, mem_be}, {26'd0, e_ctl});
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wdata", mem_wdata, e_wdata);
        if (m_rd_known) begin
            check_eq("if_rdata", if_rdata, m_if_rd);
            check_eq("d_rdata", d_rdata, m_d_rd);
        end

        if (!rst_v) begin
            m_busy     = 1'b0;
            m_if_rd    = '0;
            m_d_rd     = '0;
            m_last_d   = 1'b0;
            m_rd_known = 1'b1;
        end else if (grant) begin
            m_busy   = 1'b1;
            m_g      = cyc;
            m_own_d  = win_d;
            m_last_d = win_d;
            m_data   = (win_d && p_d_we) ? 32'h0 : mem_read(win_d ? p_d_addr : p_if_addr);
        end

        // Memory environment reacts to what the DUT actually drives
        if (mem_en) begin
            if (mem_we) begin
                old = mem_read(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) old[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr] = old;
            end else begin
                rd_sched[cyc + MEM_LAT] = mem_read(mem_addr);
            end
        end
        if (rd_sched.exists(cyc)) rd_sched.delete(cyc);

        if (rand_mode) begin
            if (e_d_gnt || !p_d_req) new_d_req(35);
            else if ($urandom_range(0, 99) < 8) p_d_req = 1'b0;
            if (e_if_gnt || !p_if_req) begin
                p_if_req  = ($urandom_range(0, 99) < 50);
                p_if_addr = rand_addr();
            end else if ($urandom_range(0, 99) < 8) begin
                p_if_req = 1'b0;
            end
            rst_v = ($urandom_range(0, 199) != 0);
        end else begin
            if (e_d_gnt) p_d_req = 1'b0;
            if (e_if_gnt) begin
                if (if_hold) p_if_addr = p_if_addr + 32'd4;
                else         p_if_req  = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_v = 1'b0; rand_mode = 1'b0; if_hold = 1'b0;
        p_if_req = 1'b0; p_if_addr = '0;
        p_d_req = 1'b0; p_d_we = 1'b0; p_d_be = '0; p_d_addr = '0; p_d_wdata = '0;
        m_busy = 1'b0; m_own_d = 1'b0; m_last_d = 1'b0; m_rd_known = 1'b0;
        m_g = 0; m_data = '0; m_if_rd = '0; m_d_rd = '0;
        run(2);
        rst_v = 1'b1;
        run(1);

        // Plain load returning a known word
        mem[32'h10] = 32'hDEAD_BEEF;
        p_d_req = 1'b1; p_d_we = 1'b0; p_d_be = 4'hF; p_d_addr = 32'h10;
        run(5);
        check_eq("load_data", d_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests, then a second tie at the next opportunity
        p_if_req = 1'b1; p_if_addr = 32'h20;
        p_d_req = 1'b1; p_d_we = 1'b0; p_d_addr = 32'h24;
        run(2);
        p_d_req = 1'b1; p_d_addr = 32'h28;
        run(9);

        // Partial store
        mem[32'h30] = 32'h0;
        p_d_req = 1'b1; p_d_we = 1'b1; p_d_be = 4'b0011;
        p_d_addr = 32'h30; p_d_wdata = 32'h1234_ABCD;
        run(5);
        check_eq("store_mem", mem_read(32'h30), 32'h0000_ABCD);
        check_eq("store_ack", d_rdata, 32'h0);

        // Back-to-back fetches with req held high
        if_hold = 1'b1; p_if_req = 1'b1; p_if_addr = 32'h40;
        run(10);
        if_hold = 1'b0; p_if_req = 1'b0;
        run(4);

        // Reset right after a load grant, then a clean fetch
        p_d_req = 1'b1; p_d_we = 1'b0; p_d_addr = 32'h10;
        run(1);
        rst_v = 1'b0;
        run(1);
        rst_v = 1'b1;
        p_if_req = 1'b1; p_if_addr = 32'h50;
        run(6);

        // Fetch request raised only while the data access is in flight
        p_d_req = 1'b1; p_d_we = 1'b0; p_d_addr = 32'h14;
        run(1);
        p_if_req = 1'b1; p_if_addr = 32'h60;
        run(2);
        p_if_req = 1'b0;
        run(4);

        rand_mode = 1'b1;
        run(RAND_CYCLES);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Shares one single-port, fixed-latency memory between the RV32I core's instruction-fetch port and its load/store port. Each side makes one request at a time with a req/gnt handshake and gets a one-cycle rvalid pulse on completion. The arbiter runs a small issue/wait/respond state machine with one transaction outstanding. It sits between `data_path` (fetch and data ports) and the unified memory model.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width; byte-enable width is DATA_W/8
- `MEM_LAT`, 2, memory read latency in cycles; legal range ≥1

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  DATA_W/8  store byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  load data / store ack, one-cycle pulse
- `d_rdata`  out  DATA_W  load data; 0 on store ack
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  valid exactly MEM_LAT cycles after the `mem_en` cycle

## Operation

**States**
- `IDLE`, `WAIT`, `RESP`.
- A grant may be issued in `IDLE` or `RESP`, never in `WAIT`.

**Grant cycle T**
- The winner's `*_gnt` is high for exactly one cycle.
- `mem_en`, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are driven combinationally from the winner's inputs in that same cycle.
- Fetch drives `mem_we`=0 and `mem_be`=all ones.
- Outside a grant cycle, all `mem_*` outputs are 0.

**Arbitration**
- Fixed priority: data beats fetch.
- Only the current cycle's `req` is sampled. A requester may withdraw `req` before `gnt` without any side effect.
- Requesters must hold `addr`, `we`, `be` and `wdata` stable while `req` is high.

**WAIT**
- A down-counter of width `$clog2(MEM_LAT+1)` is loaded with MEM_LAT at grant.
- On the cycle the counter reaches 1, `mem_rdata` is captured into the owner's rdata register; the state then moves to `RESP`.

**RESP**
- The owner's `rvalid` is high for one cycle, with registered `rdata`.
- Stores return `rdata`=0.
- `rdata` holds its value until the next response to that port.

**Transitions**
- `IDLE` → `WAIT` on any grant.
- `WAIT` → `RESP` when the count expires.
- `RESP` → `WAIT` on a new grant, otherwise `RESP` → `IDLE`.

**Other rules**
- No address alignment check; addresses pass through unchanged.

## Timing
- Grant at T gives `rvalid` at T+MEM_LAT+1. This applies to both loads and stores.
- Back-to-back: the next grant can occur in the `RESP` cycle, so throughput is one access per MEM_LAT+1 cycles.
- Both requests at the same cycle: the data port wins at T, and fetch is granted no earlier than T+MEM_LAT+1.
- Reset (`reset`=0):
  - State → `IDLE`; counter, owner, `if_rdata` and `d_rdata` → 0.
  - All `gnt`, `rvalid` and `mem_*` outputs are forced to 0 in that cycle.
- Reset mid-`WAIT` abandons the transaction: no `rvalid` is produced, and late `mem_rdata` is ignored.
- `req` asserted during `WAIT` is held off (`gnt`=0) until `RESP`.

## Configuration
- `ARB_RR_EN` defined: round-robin between the two ports.
  - On a tie, the port not granted most recently wins.
  - The last-granted register resets to fetch, so the first tie goes to data.
- `ARB_RR_EN` undefined: fixed data-over-fetch priority, with no extra state.

## Structure
- Package `rv32i_mem_pkg` contains:
  - `arb_state_t` enum (`IDLE`, `WAIT`, `RESP`);
  - `owner_t` enum (`OWN_IF`, `OWN_D`);
  - default width localparams.
- One sub-module, `mem_arb_pick`: a combinational picker taking `if_req`, `d_req` and last-grant, and returning grant-valid and the winner. It contains the only `ARB_RR_EN`-dependent logic.

## Test plan
- MEM_LAT=2; load `d_addr`=0x10, with the memory returning 0xDEADBEEF → `d_gnt` at T, `d_rvalid` at T+3, `d_rdata`=0xDEADBEEF, `if_rvalid` stays 0.
- `if_req` and `d_req` both high at T → `d_gnt` at T and `if_gnt` at T+3.
  - Fixed mode: repeat the tie at the next grant opportunity → data wins again.
  - `ARB_RR_EN` mode: fetch wins the second tie.
- Store `d_be`=4'b0011, `d_wdata`=0x1234ABCD → one `mem_en` cycle with `mem_we`=1 and matching be/data; `d_rvalid` at T+3 with `d_rdata`=0.
- Fetch requests back to back with `if_req` held high → `if_gnt` every 3 cycles, and each `if_rvalid` coincides with the next `if_gnt`.
- Reset asserted one cycle after a load grant → no `d_rvalid` ever; a fetch granted after reset releases reads its own data correctly.
- `if_req` pulsed during `WAIT` only, then dropped before `RESP` → no `if_gnt`, no `mem_en`.
